// File: rtl/inst_rom_loader_if.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_if
//   Bundles the fetch port and the byte-stream load port of inst_rom_loader.
//   Parameter AW is the word-address width of the attached memory.
//   Optional macro: INST_ROM_CHECKSUM_EN adds load_csum.
//
//   Signals (direction seen from the slave, i.e. the loader/ROM):
//     ce, addr[31:0]            in   fetch enable / fetch byte address
//     inst[31:0]                out  fetched instruction (0 when not valid)
//     load_start                in   begin a new load at word 0
//     load_byte[7:0]            in   program byte
//     load_valid, load_last     in   byte valid / final byte of image
//     load_ready, load_busy     out  byte accepted this cycle / load running
//     load_done, load_ovf       out  image complete / sticky overflow
//     load_words[AW:0]          out  words written by current/last load
//     load_csum[31:0]           out  (INST_ROM_CHECKSUM_EN only) word sum
//
//   Modports: master = core + host side, slave = inst_rom_loader.
// ---------------------------------------------------------------------------
interface inst_rom_loader_if #(
    parameter int AW = 10
);
    logic          ce;
    logic [31:0]   addr;
    logic [31:0]   inst;
    logic          load_start;
    logic [7:0]    load_byte;
    logic          load_valid;
    logic          load_last;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_ovf;
    logic [AW:0]   load_words;
`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0]   load_csum;
`endif

    modport master (
        output ce, addr, load_start, load_byte, load_valid, load_last,
        input  inst, load_ready, load_busy, load_done, load_ovf, load_words
`ifdef INST_ROM_CHECKSUM_EN
        , input load_csum
`endif
    );

    modport slave (
        input  ce, addr, load_start, load_byte, load_valid, load_last,
        output inst, load_ready, load_busy, load_done, load_ovf, load_words
`ifdef INST_ROM_CHECKSUM_EN
        , output load_csum
`endif
    );
endinterface

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//   Instruction memory for the core fetch port with a byte-stream loader.
//   Fetch is combinational (word returned in the same cycle so if_id can
//   capture it on the next edge); the loader packs bytes big-endian into
//   32-bit words and writes them from word 0 upward.
//
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   inst_rom_loader_if.slave (fetch + load signals, see interface)
//
//   Parameter AW: word-address width, memory depth is 2**AW words.
//   Optional macro INST_ROM_CHECKSUM_EN: adds load_csum, the mod-2^32 sum
//   of all words written by the current load.
// ---------------------------------------------------------------------------
module inst_rom_loader #(
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     word_q, word_d;     // partial word; unfilled lanes stay zero
    logic [AW:0]     words_q, words_d;
    logic            full_q, full_d;     // DONE was reached by filling memory
    logic            ovf_q, ovf_d;

    // Fetch must answer in the same cycle, so this is an asynchronous-read
    // array (maps to distributed RAM); contents survive reset.
    logic [31:0]     mem [DEPTH];

    logic            start_ok;
    logic            accept;
    logic            wr_en;
    logic [31:0]     wr_data;
    logic            addr_unused;

    assign start_ok = bus.load_start && (state_q != LOAD);
    assign accept   = (state_q == LOAD) && bus.load_valid;
    // Byte n of a word lands in lane 3-n; a word completes on the 4th byte
    // or early on load_last, with the untouched low lanes left as zero.
    assign wr_data  = word_q | ({24'h0, bus.load_byte} << {~cnt_q, 3'b000});
    assign wr_en    = accept && ((cnt_q == 2'd3) || bus.load_last);

    // Byte offset and address bits above the memory range are ignored.
    assign addr_unused = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            words_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            words_q <= words_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    // Memory write; a partial word pending at reset is simply never written.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_q] <= wr_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (bus.load_start) state_d = LOAD;
            LOAD:       if (wr_en && (bus.load_last || (&ptr_q))) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next-state; a start takes precedence over a same-cycle byte.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        words_d = words_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        if (start_ok) begin
            ptr_d   = '0;
            cnt_d   = '0;
            word_d  = '0;
            words_d = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            if (wr_en) begin
                ptr_d   = ptr_q + 1'b1;
                cnt_d   = '0;
                word_d  = '0;
                words_d = words_q + 1'b1;
                if (!bus.load_last && (&ptr_q)) full_d = 1'b1;
            end else begin
                cnt_d   = cnt_q + 2'd1;
                word_d  = wr_data;
            end
        end else if ((state_q == DONE) && full_q && bus.load_valid) begin
            ovf_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        bus.load_ready = (state_q == LOAD);
        bus.load_busy  = (state_q == LOAD);
        bus.load_done  = (state_q == DONE);
        bus.load_ovf   = ovf_q;
        bus.load_words = words_q;
        // nop while loading so the core never runs a half-written image
        bus.inst       = (bus.ce && (state_q != LOAD)) ? mem[bus.addr[AW+1:2]] : 32'h0;
    end

`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok)   csum_d = '0;
        else if (wr_en) csum_d = csum_q + wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign bus.load_csum = csum_q;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  lbyte = '0;
    logic        lvalid = 1'b0;
    logic        llast = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    // Main instance (AW=10) and a tiny one (AW=2) for the full/overflow case.
    inst_rom_loader_if #(.AW(10)) if0 ();
    inst_rom_loader_if #(.AW(2))  if2 ();

    assign if0.ce = ce;       assign if2.ce = ce;
    assign if0.addr = addr;   assign if2.addr = addr;
    assign if0.load_start = start0;
    assign if2.load_start = start2;
    assign if0.load_byte = lbyte;   assign if2.load_byte = lbyte;
    assign if0.load_valid = lvalid; assign if2.load_valid = lvalid;
    assign if0.load_last = llast;   assign if2.load_last = llast;

    inst_rom_loader #(.AW(10)) dut (.clk(clk), .rst(rst), .bus(if0));
    inst_rom_loader #(.AW(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        lbyte  = b;
        llast  = last;
        lvalid = 1'b1;
        tick();
        lvalid = 1'b0;
        llast  = 1'b0;
    endtask

    task automatic start(input bit sel);
        if (sel) start2 = 1'b1;
        else     start0 = 1'b1;
        tick();
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    // Expected word is queued when the fetch is driven, popped on sampling.
    task automatic fetch(input bit sel, input logic [31:0] a, input logic c,
                         input logic [31:0] exp, input string tag);
        logic [31:0] obs;
        sb.push_back(exp);
        ce   = c;
        addr = a;
        @(negedge clk);
        obs = sel ? if2.inst : if0.inst;
        chk(tag, obs, sb.pop_front());
        ce = 1'b0;
    endtask

    initial begin
        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", if0.inst, 32'h0);
        chk("rst_ready", {31'h0, if0.load_ready}, 32'h0);
        chk("rst_busy", {31'h0, if0.load_busy}, 32'h0);
        chk("rst_done", {31'h0, if0.load_done}, 32'h0);
        chk("rst_ovf", {31'h0, if0.load_ovf}, 32'h0);
        chk("rst_words", {21'h0, if0.load_words}, 32'h0);
        chk("rst_words2", {29'h0, if2.load_words}, 32'h0);
`ifdef INST_ROM_CHECKSUM_EN
        chk("rst_csum", if0.load_csum, 32'h0);
`endif
        rst = 1'b0;
        tick();

        // 2. two-word image
        start(1'b0);
        chk("t2_busy", {31'h0, if0.load_busy}, 32'h1);
        chk("t2_ready", {31'h0, if0.load_ready}, 32'h1);
        send_byte(8'h3C, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        send_byte(8'h34, 1'b0); send_byte(8'h21, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b1);
        chk("t2_done", {31'h0, if0.load_done}, 32'h1);
        chk("t2_busy_off", {31'h0, if0.load_busy}, 32'h0);
        chk("t2_words", {21'h0, if0.load_words}, 32'h2);
        fetch(1'b0, 32'h0, 1'b1, 32'h3C011234, "t2_mem0");
        fetch(1'b0, 32'h4, 1'b1, 32'h34210005, "t2_mem1");
        fetch(1'b0, 32'h6, 1'b1, 32'h34210005, "t2_lowbits");
        fetch(1'b0, 32'h1004, 1'b1, 32'h34210005, "t2_wrap");

        // 3. short image, last byte mid-word
        start(1'b0);
        chk("t3_done_clr", {31'h0, if0.load_done}, 32'h0);
        chk("t3_words_clr", {21'h0, if0.load_words}, 32'h0);
        send_byte(8'hAA, 1'b0);
        fetch(1'b0, 32'h0, 1'b1, 32'h0, "t3_nop_busy");
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        chk("t3_done", {31'h0, if0.load_done}, 32'h1);
        chk("t3_words", {21'h0, if0.load_words}, 32'h1);
        fetch(1'b0, 32'h0, 1'b1, 32'hAABBCC00, "t3_pad");
        fetch(1'b0, 32'h4, 1'b1, 32'h34210005, "t3_mem1_kept");

        // 4. AW=2 memory filled, then one extra byte
        start(1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0);
        chk("t4_done", {31'h0, if2.load_done}, 32'h1);
        chk("t4_ready", {31'h0, if2.load_ready}, 32'h0);
        chk("t4_words", {29'h0, if2.load_words}, 32'h4);
        chk("t4_ovf_pre", {31'h0, if2.load_ovf}, 32'h0);
        send_byte(8'hEE, 1'b0);
        chk("t4_ovf", {31'h0, if2.load_ovf}, 32'h1);
        fetch(1'b1, 32'h0, 1'b1, 32'h10111213, "t4_mem0");
        fetch(1'b1, 32'hC, 1'b1, 32'h1C1D1E1F, "t4_mem3");
        fetch(1'b1, 32'h10, 1'b1, 32'h10111213, "t4_wrap");

        // 5. start with a same-cycle byte, then reset after 6 bytes
        start0 = 1'b1; lbyte = 8'h77; lvalid = 1'b1;
        tick();
        start0 = 1'b0; lvalid = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'h0, if0.load_busy}, 32'h0);
        chk("t5_done", {31'h0, if0.load_done}, 32'h0);
        chk("t5_words", {21'h0, if0.load_words}, 32'h0);
        fetch(1'b0, 32'h0, 1'b1, 32'h11121314, "t5_mem0");
        fetch(1'b0, 32'h4, 1'b1, 32'h34210005, "t5_mem1_kept");

        // 6. ce=0 gives nop; checksum image
        fetch(1'b0, 32'h0, 1'b0, 32'h0, "t6_ce_off");
        tick();
        start(1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b1);
        chk("t6_words", {21'h0, if0.load_words}, 32'h2);
        fetch(1'b0, 32'h0, 1'b1, 32'h00000001, "t6_mem0");
        fetch(1'b0, 32'h4, 1'b1, 32'hFFFFFFFF, "t6_mem1");
        fetch(1'b0, 32'h4, 1'b0, 32'h0, "t6_ce_off2");
`ifdef INST_ROM_CHECKSUM_EN
        chk("t6_csum", if0.load_csum, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
